serdesphy_prbs_checker: RTL and testbench
=========================================

Name: serdesphy_prbs_checker

Overview:
RX-side PRBS-7 checker (x^7 + x^6 + 1) for the SerDes PHY loopback and BIST path. It consumes 8-bit deserialized words at 24 MHz and predicts each next word from the TX word-seeding rule. It acquires lock and counts bit errors in a saturating counter. It sits after the deserializer/aligner and reports status to the CSR block.

Parameters:
LOCK_COUNT, 4, consecutive matching words needed to enter LOCKED (range 1..15)
LOSS_COUNT, 4, consecutive errored words in LOCKED that force a return to HUNT (range 1..15)
ERR_CNT_W, 16, width of the bit-error counter

Ports:
clk  input  1  24 MHz clock
rst_n  input  1  active-low asynchronous reset
enable  input  1  checker enable; low forces HUNT and holds the counters
clear_errors  input  1  synchronous pulse; zeroes err_count and err_word_count and clears err_sticky
rx_data  input  8  received word; bit 0 is the earliest bit
rx_valid  input  1  rx_data valid this cycle
rx_ready  output  1  equals enable (combinational); a word is accepted when rx_valid & rx_ready
prbs_lock  output  1  high in LOCKED
err_sticky  output  1  set on any bit error while LOCKED; cleared only by clear_errors or reset
err_count  output  ERR_CNT_W  saturating count of bit errors while LOCKED
err_word_count  output  ERR_CNT_W  saturating count of errored words while LOCKED
err_pulse  output  1  one-cycle pulse for each errored word while LOCKED

Behaviour:
Reset and enable:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- All outputs are registered except rx_ready. Reset values: prbs_lock=0, err_sticky=0, err_count=0, err_word_count=0, err_pulse=0, FSM=HUNT, expected word=0, match/miss counters=0.
Word expansion:
- expand(seed[6:0]) runs 8 LFSR steps from the 7-bit state s. For i=0..7: out[i]=s[6], then s={s[5:0], s[6]^s[5]}.
- TX rule: the seed for word n+1 is word n[6:0].
- Reference values: expand(7'h7F)=8'h7F (fixed point); expand(7'h01)=8'h40; expand(7'h40)=8'h81.
Latency:
- Status outputs update on the clock edge after the accepted word, one cycle of latency.
- err_pulse is high for exactly one cycle per errored word.
FSM states, evaluated only on accepted words:
- HUNT: if rx_data[6:0]!=0, set exp=expand(rx_data[6:0]), match_cnt=0 and go to VERIFY. An all-zero seed is rejected and the FSM stays in HUNT.
- VERIFY, on a match (rx_data==exp): match_cnt++, exp=expand(rx_data[6:0]). Go to LOCKED when match_cnt reaches LOCK_COUNT.
- VERIFY, on a mismatch: reseed from rx_data as in HUNT and clear match_cnt. An all-zero seed sends the FSM to HUNT.
- LOCKED (flywheel): the next exp is expand(exp[6:0]) and never takes rx_data, so a single corrupted word is counted once.
- LOCKED, on a mismatch: err_count += popcount(rx_data^exp); err_word_count++; err_pulse=1; err_sticky=1; miss_cnt++. When miss_cnt reaches LOSS_COUNT, go to HUNT, drop prbs_lock and clear miss_cnt.
- LOCKED, on a match: miss_cnt=0.
- Errors are counted only in LOCKED. Words seen in HUNT and VERIFY never increment the counters.
Arithmetic and boundary rules:
- Counters saturate at all-ones and never wrap. The popcount add clamps to the maximum value.
- rx_valid low, or enable low: no state change beyond the enable rule.
- enable low: FSM=HUNT and prbs_lock=0 on the next edge. Counters and sticky bits hold their values.
- clear_errors in the same cycle as an errored word: the clear wins and the counters read 0.
- Reset mid-stream: everything returns to reset values immediately (asynchronous). The block reacquires through HUNT.

Decomposition:
- Shared package serdesphy_prbs_pkg holds:
  - state encodings HUNT=2'b00, VERIFY=2'b01, LOCKED=2'b10
  - the PRBS-7 tap positions
  - the 8-bit word expansion function
- The generator and the checker both use this package, so the two directions match.
- One natural sub-module is serdesphy_prbs_err_counter: a saturating counter with increment and clear inputs, instantiated twice.

Test Plan:
1. Stream 0x01, 0x40, 0x81, continuing per the rule, with LOCK_COUNT=4. prbs_lock rises one cycle after the 5th accepted word; all counters stay 0.
2. Continuous 0x7F stream. The checker locks after 5 words and err_count stays 0.
3. While locked, inject one word with 3 flipped bits. err_count=3, err_word_count=1, one err_pulse, err_sticky=1. The next correct word still matches, so the flywheel gives no double count.
4. While locked, feed 4 consecutive garbage words. prbs_lock falls one cycle after the 4th. A following valid stream reacquires lock, and the counters keep their old values.
5. An all-zero stream for 20 words never locks and the counters stay 0. Pulse clear_errors after scenario 3: all counters read 0 and err_sticky=0.
6. Preload err_count at 16'hFFFE and inject a word with 8 flipped bits. err_count=16'hFFFF. Separately, deassert rst_n mid-word and check that all outputs reach reset values without waiting for a clock edge.

Source files
------------

// File: rtl/serdesphy_prbs_pkg.sv
// PRBS-7 (x^7 + x^6 + 1) shared definitions for the SerDes PHY.
// Used by both the TX generator and the RX checker.
package serdesphy_prbs_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'b00,
    VERIFY = 2'b01,
    LOCKED = 2'b10
  } prbs_state_t;

  localparam int PRBS_TAP_HI = 6;
  localparam int PRBS_TAP_LO = 5;

  // Eight LFSR steps from a 7-bit seed; bit 0 is the earliest bit.
  function automatic logic [7:0] prbs7_expand(input logic [6:0] seed);
    logic [6:0] s;
    logic [7:0] o;
    s = seed;
    o = '0;
    for (int i = 0; i < 8; i++) begin
      o[i] = s[PRBS_TAP_HI];
      s = {s[5:0], s[PRBS_TAP_HI] ^ s[PRBS_TAP_LO]};
    end
    return o;
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/serdesphy_prbs_err_counter.sv
// Saturating up-counter with a variable increment.
// A clear in the same cycle as an increment wins.
module serdesphy_prbs_err_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] amt,
  output logic [W-1:0] count
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic [W:0]   sum;

  // Next count: clear first, otherwise add and clamp on carry-out.
  always_comb begin
    sum   = {1'b0, cnt_q} + {1'b0, amt};
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = sum[W] ? '1 : sum[W-1:0];
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/serdesphy_prbs_checker.sv
// RX PRBS-7 checker: hunts for a seed, verifies, then flywheels.
// Counts bit and word errors only while locked.
module serdesphy_prbs_checker
  import serdesphy_prbs_pkg::*;
#(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 4,
  parameter int ERR_CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 clear_errors,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output logic                 prbs_lock,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [ERR_CNT_W-1:0] err_word_count,
  output logic                 err_pulse
);

  prbs_state_t state_q, state_d;
  logic [7:0]  exp_q, exp_d;
  logic [3:0]  match_q, match_d;
  logic [3:0]  miss_q, miss_d;
  logic        lock_q, lock_d;
  logic        sticky_q, sticky_d;
  logic        pulse_q, pulse_d;
  logic        err_word;
  logic [7:0]  diff;
  logic        hit;
  logic        seed_ok;
  logic [ERR_CNT_W-1:0] bit_amt;

  assign rx_ready = enable;
  assign diff     = rx_data ^ exp_q;
  assign hit      = (diff == 8'h00);
  assign seed_ok  = (rx_data[6:0] != 7'h00);
  assign bit_amt  = ERR_CNT_W'(popcount8(diff));

  // Acquisition FSM and flywheel; acts only on accepted words.
  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    match_d  = match_q;
    miss_d   = miss_q;
    sticky_d = sticky_q;
    pulse_d  = 1'b0;
    err_word = 1'b0;
    if (!enable) begin
      state_d = HUNT;
      match_d = '0;
      miss_d  = '0;
    end else if (rx_valid) begin
      unique case (state_q)
        HUNT: begin
          if (seed_ok) begin
            exp_d   = prbs7_expand(rx_data[6:0]);
            match_d = '0;
            state_d = VERIFY;
          end
        end
        VERIFY: begin
          if (hit) begin
            exp_d = prbs7_expand(rx_data[6:0]);
            if (match_q == 4'(LOCK_COUNT - 1)) begin
              match_d = '0;
              miss_d  = '0;
              state_d = LOCKED;
            end else begin
              match_d = match_q + 4'd1;
            end
          end else begin
            match_d = '0;
            if (seed_ok) begin
              exp_d = prbs7_expand(rx_data[6:0]);
            end else begin
              state_d = HUNT;
            end
          end
        end
        LOCKED: begin
          exp_d = prbs7_expand(exp_q[6:0]);
          if (hit) begin
            miss_d = '0;
          end else begin
            err_word = 1'b1;
            pulse_d  = 1'b1;
            sticky_d = 1'b1;
            if (miss_q == 4'(LOSS_COUNT - 1)) begin
              miss_d  = '0;
              state_d = HUNT;
            end else begin
              miss_d = miss_q + 4'd1;
            end
          end
        end
        default: begin
          state_d = HUNT;
        end
      endcase
    end
    if (clear_errors) begin
      sticky_d = 1'b0;
    end
    lock_d = (state_d == LOCKED);
  end

  // State and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HUNT;
      exp_q    <= '0;
      match_q  <= '0;
      miss_q   <= '0;
      lock_q   <= 1'b0;
      sticky_q <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      lock_q   <= lock_d;
      sticky_q <= sticky_d;
      pulse_q  <= pulse_d;
    end
  end

  serdesphy_prbs_err_counter #(
    .W(ERR_CNT_W)
  ) u_bit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear_errors),
    .inc   (err_word),
    .amt   (bit_amt),
    .count (err_count)
  );

  serdesphy_prbs_err_counter #(
    .W(ERR_CNT_W)
  ) u_word_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear_errors),
    .inc   (err_word),
    .amt   (ERR_CNT_W'(1)),
    .count (err_word_count)
  );

  assign prbs_lock  = lock_q;
  assign err_sticky = sticky_q;
  assign err_pulse  = pulse_q;

endmodule

// File: tb/tb_serdesphy_prbs_checker.sv
// Scoreboard bench for serdesphy_prbs_checker.
// Stimulus pushes expected status; a monitor pops and compares.
module tb_serdesphy_prbs_checker;

  localparam int W = 16;

  typedef struct packed {
    logic         lock;
    logic         sticky;
    logic         pulse;
    logic [W-1:0] ec;
    logic [W-1:0] wc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         enable = 1'b0;
  logic         clear_errors = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic         rx_valid = 1'b0;
  logic         rx_ready;
  logic         prbs_lock;
  logic         err_sticky;
  logic [W-1:0] err_count;
  logic [W-1:0] err_word_count;
  logic         err_pulse;

  int errors = 0;
  int checks = 0;
  int words  = 0;

  exp_t         sb_q[$];
  logic [W-1:0] m_ec = '0;
  logic [W-1:0] m_wc = '0;
  logic         m_sticky = 1'b0;
  logic         acc_seen = 1'b0;

  always #20 clk = ~clk;

  serdesphy_prbs_checker #(
    .LOCK_COUNT (4),
    .LOSS_COUNT (4),
    .ERR_CNT_W  (W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .clear_errors   (clear_errors),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .prbs_lock      (prbs_lock),
    .err_sticky     (err_sticky),
    .err_count      (err_count),
    .err_word_count (err_word_count),
    .err_pulse      (err_pulse)
  );

  always @(posedge clk) acc_seen <= rst_n && rx_valid && rx_ready;

  always @(negedge clk) begin
    if (acc_seen) begin
      exp_t e;
      exp_t a;
      a.lock   = prbs_lock;
      a.sticky = err_sticky;
      a.pulse  = err_pulse;
      a.ec     = err_count;
      a.wc     = err_word_count;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow: output seen with no expectation");
      end else begin
        e = sb_q.pop_front();
        words++;
        if (a !== e) begin
          errors++;
          $display("FAIL word%0d: lock=%0b sticky=%0b pulse=%0b ec=%h wc=%h, required lock=%0b sticky=%0b pulse=%0b ec=%h wc=%h",
                   words, a.lock, a.sticky, a.pulse, a.ec, a.wc,
                   e.lock, e.sticky, e.pulse, e.ec, e.wc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic send(input logic [7:0] good, input logic [7:0] flip,
                      input logic lock_after, input logic counted,
                      input logic clr);
    exp_t e;
    int   s;
    rx_data      = good ^ flip;
    rx_valid     = 1'b1;
    clear_errors = clr;
    @(posedge clk);
    e.pulse = 1'b0;
    if (counted && flip != 8'h00) begin
      s = int'(m_ec) + $countones(flip);
      m_ec = (s > 65535) ? 16'hFFFF : W'(s);
      if (m_wc != 16'hFFFF) m_wc = m_wc + 16'd1;
      m_sticky = 1'b1;
      e.pulse  = 1'b1;
    end
    if (clr) begin
      m_ec     = '0;
      m_wc     = '0;
      m_sticky = 1'b0;
    end
    e.lock   = lock_after;
    e.sticky = m_sticky;
    e.ec     = m_ec;
    e.wc     = m_wc;
    sb_q.push_back(e);
    #1;
    rx_valid     = 1'b0;
    clear_errors = 1'b0;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    #5;
    check("rst_lock", 32'(prbs_lock), 0);
    check("rst_sticky", 32'(err_sticky), 0);
    check("rst_ec", 32'(err_count), 0);
    check("rst_wc", 32'(err_word_count), 0);
    check("rst_pulse", 32'(err_pulse), 0);
    check("rst_ready", 32'(rx_ready), 0);
    #30;
    rst_n  = 1'b1;
    enable = 1'b1;
    @(posedge clk);
    #1;
    check("ready_en", 32'(rx_ready), 1);

    // All-zero stream never locks.
    repeat (20) send(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

    // 0x01, 0x40, 0x81, 0x40, 0x81 ... locks after the 5th word.
    send(8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
    send(8'h40, 8'h00, 1'b0, 1'b0, 1'b0);
    send(8'h81, 8'h00, 1'b0, 1'b0, 1'b0);
    send(8'h40, 8'h00, 1'b0, 1'b0, 1'b0);
    send(8'h81, 8'h00, 1'b1, 1'b0, 1'b0);
    send(8'h40, 8'h00, 1'b1, 1'b1, 1'b0);
    // Three flipped bits, then flywheel continues cleanly.
    send(8'h81, 8'h07, 1'b1, 1'b1, 1'b0);
    send(8'h40, 8'h00, 1'b1, 1'b1, 1'b0);
    send(8'h81, 8'h00, 1'b1, 1'b1, 1'b0);
    send(8'h40, 8'h01, 1'b1, 1'b1, 1'b0);

    // Standalone clear.
    clear_errors = 1'b1;
    @(posedge clk);
    #1;
    clear_errors = 1'b0;
    m_ec = '0;
    m_wc = '0;
    m_sticky = 1'b0;
    check("clr_ec", 32'(err_count), 0);
    check("clr_wc", 32'(err_word_count), 0);
    check("clr_sticky", 32'(err_sticky), 0);
    check("clr_lock", 32'(prbs_lock), 1);

    // Clear coincident with an errored word wins.
    send(8'h81, 8'h01, 1'b1, 1'b1, 1'b1);
    send(8'h40, 8'h00, 1'b1, 1'b1, 1'b0);

    // Four garbage words drop lock after the 4th.
    send(8'h81, 8'hFF, 1'b1, 1'b1, 1'b0);
    send(8'h40, 8'hFF, 1'b1, 1'b1, 1'b0);
    send(8'h81, 8'hFF, 1'b1, 1'b1, 1'b0);
    send(8'h40, 8'hFF, 1'b0, 1'b1, 1'b0);

    // Reacquire on a 0x7F stream; counters keep their values.
    repeat (4) send(8'h7F, 8'h00, 1'b0, 1'b0, 1'b0);
    send(8'h7F, 8'h00, 1'b1, 1'b0, 1'b0);
    send(8'h7F, 8'h00, 1'b1, 1'b1, 1'b0);

    // Enable low forces HUNT and holds counters.
    enable = 1'b0;
    #1;
    check("ready_dis", 32'(rx_ready), 0);
    @(posedge clk);
    #1;
    check("dis_lock", 32'(prbs_lock), 0);
    check("dis_ec", 32'(err_count), 32'(m_ec));
    check("dis_wc", 32'(err_word_count), 32'(m_wc));
    enable = 1'b1;

    // VERIFY mismatch reseeds and restarts the match count.
    send(8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
    send(8'h40, 8'h00, 1'b0, 1'b0, 1'b0);
    send(8'h7F, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (3) send(8'h7F, 8'h00, 1'b0, 1'b0, 1'b0);
    send(8'h7F, 8'h00, 1'b1, 1'b0, 1'b0);
    idle(2);

    // Asynchronous reset mid-word.
    rx_data  = 8'h80;
    rx_valid = 1'b1;
    #5;
    rst_n = 1'b0;
    #1;
    check("arst_lock", 32'(prbs_lock), 0);
    check("arst_sticky", 32'(err_sticky), 0);
    check("arst_ec", 32'(err_count), 0);
    check("arst_wc", 32'(err_word_count), 0);
    check("arst_pulse", 32'(err_pulse), 0);
    rx_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_ec = '0;
    m_wc = '0;
    m_sticky = 1'b0;
    @(posedge clk);
    #1;

    // Relock and drive the bit counter to saturation.
    repeat (4) send(8'h7F, 8'h00, 1'b0, 1'b0, 1'b0);
    send(8'h7F, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2730; i++) begin
      repeat (3) send(8'h7F, 8'hFF, 1'b1, 1'b1, 1'b0);
      send(8'h7F, 8'h00, 1'b1, 1'b1, 1'b0);
    end
    send(8'h7F, 8'hFF, 1'b1, 1'b1, 1'b0);
    send(8'h7F, 8'h3F, 1'b1, 1'b1, 1'b0);
    send(8'h7F, 8'h00, 1'b1, 1'b1, 1'b0);
    idle(1);
    check("pre_sat_ec", 32'(err_count), 32'h0000FFFE);
    send(8'h7F, 8'hFF, 1'b1, 1'b1, 1'b0);
    send(8'h7F, 8'h00, 1'b1, 1'b1, 1'b0);
    send(8'h7F, 8'h0F, 1'b1, 1'b1, 1'b0);
    idle(3);
    check("sat_ec", 32'(err_count), 32'h0000FFFF);
    check("sat_wc", 32'(err_word_count), 32'(16'd8194));
    check("sb_drain", 32'(sb_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
